// File: rtl/lfsr_rng_scheduler.sv
// Shares one Fibonacci LFSR between NREQ requesters with round-robin arbitration,
// advancing it STEPS times per grant and delivering the word with a one-hot grant pulse.
module lfsr_rng_scheduler #(
  parameter int              WIDTH = 8,
  parameter int              NREQ  = 4,
  parameter logic [WIDTH-1:0] TAPS = 8'hB8,
  parameter logic [WIDTH-1:0] SEED = 8'h01,
  parameter int              STEPS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_data,
  output logic [NREQ-1:0]  gnt,
  output logic [WIDTH-1:0] rnd_out,
  output logic             rnd_valid,
  output logic             busy
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP  = 2'd1,
    GRANT = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] lfsr_r;
  logic [PW-1:0]    rr_ptr_r;
  logic [PW-1:0]    sel_r;
  logic [7:0]       step_cnt_r;
  logic [NREQ-1:0]  gnt_r;
  logic [WIDTH-1:0] rnd_out_r;
  logic             rnd_valid_r;
  logic             busy_r;

  logic [PW-1:0]    pick_s;
  logic             any_req_s;
  logic [WIDTH-1:0] shift_s;
  logic [WIDTH-1:0] seed_val_s;

  function automatic logic [WIDTH-1:0] lfsr_shift(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], ^(v & TAPS)};
  endfunction

  // First requester at or after the pointer, wrapping modulo NREQ.
  function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [PW-1:0] p);
    logic [PW-1:0] pick;
    logic [PW-1:0] idx_v;
    logic          found;
    logic          hit;
    pick  = p;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx_v = PW'((int'(p) + i) % NREQ);
      hit   = !found && r[idx_v];
      pick  = hit ? idx_v : pick;
      found = found | hit;
    end
    return pick;
  endfunction

  function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] s);
    return (int'(s) == NREQ - 1) ? {PW{1'b0}} : s + {{(PW-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] s);
    return {{(NREQ-1){1'b0}}, 1'b1} << s;
  endfunction

  // Arbitration pick, next LFSR value and sanitised seed.
  always_comb begin
    pick_s    = rr_pick(req, rr_ptr_r);
    any_req_s = |req;
    shift_s   = lfsr_shift(lfsr_r);
    if (seed_data == {WIDTH{1'b0}}) begin
      seed_val_s = SEED;
    end else begin
      seed_val_s = seed_data;
    end
  end

  // Scheduler FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      lfsr_r      <= SEED;
      rr_ptr_r    <= {PW{1'b0}};
      sel_r       <= {PW{1'b0}};
      step_cnt_r  <= 8'd0;
      gnt_r       <= {NREQ{1'b0}};
      rnd_out_r   <= {WIDTH{1'b0}};
      rnd_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          gnt_r       <= {NREQ{1'b0}};
          rnd_valid_r <= 1'b0;
          // Seeding wins over a same-cycle request; the request is seen next cycle.
          if (seed_load) begin
            lfsr_r <= seed_val_s;
          end else if (any_req_s) begin
            sel_r      <= pick_s;
            step_cnt_r <= 8'(STEPS - 1);
            busy_r     <= 1'b1;
            state_r    <= STEP;
          end
        end
        STEP: begin
          lfsr_r <= shift_s;
          if (step_cnt_r == 8'd0) begin
            gnt_r       <= onehot(sel_r);
            rnd_valid_r <= 1'b1;
            rnd_out_r   <= shift_s;
            state_r     <= GRANT;
          end else begin
            step_cnt_r <= step_cnt_r - 8'd1;
          end
        end
        GRANT: begin
          gnt_r       <= {NREQ{1'b0}};
          rnd_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          rr_ptr_r    <= rr_next(sel_r);
          state_r     <= IDLE;
        end
        default: begin
          gnt_r       <= {NREQ{1'b0}};
          rnd_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign gnt       = gnt_r;
  assign rnd_out   = rnd_out_r;
  assign rnd_valid = rnd_valid_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_lfsr_rng_scheduler.sv
// Directed, table-driven bench for lfsr_rng_scheduler (STEPS=8 instance plus a STEPS=1
// instance used for the full-period sweep).
module tb_lfsr_rng_scheduler;

  logic       clk;
  logic       reset, reset1;
  logic [3:0] req, req1;
  logic       seed_load, seed_load1;
  logic [7:0] seed_data, seed_data1;
  logic [3:0] gnt, gnt1;
  logic [7:0] rnd_out, rnd_out1;
  logic       rnd_valid, rnd_valid1;
  logic       busy, busy1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] exp_gnt;
    logic [7:0] exp_rnd;
    logic [7:0] exp_lat;
  } vec_t;

  vec_t tbl [5];

  lfsr_rng_scheduler dut (
    .clk(clk), .reset(reset), .req(req), .seed_load(seed_load), .seed_data(seed_data),
    .gnt(gnt), .rnd_out(rnd_out), .rnd_valid(rnd_valid), .busy(busy)
  );

  lfsr_rng_scheduler #(.STEPS(1)) dut1 (
    .clk(clk), .reset(reset1), .req(req1), .seed_load(seed_load1), .seed_data(seed_data1),
    .gnt(gnt1), .rnd_out(rnd_out1), .rnd_valid(rnd_valid1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_model(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Grant must always be one-hot (or zero) and rnd_valid must track it.
  always @(negedge clk) begin
    checks++;
    if ((rnd_valid !== (|gnt)) || ($countones(gnt) > 1) ||
        (rnd_valid1 !== (|gnt1)) || ($countones(gnt1) > 1)) begin
      errors++;
      $display("FAIL onehot_valid: gnt=%b rv=%b gnt1=%b rv1=%b", gnt, rnd_valid, gnt1, rnd_valid1);
    end
  end

  task automatic wait_gnt(input bit which, output int lat, output int bcnt,
                          output logic [3:0] g, output logic [7:0] r, output logic v);
    lat = 0; bcnt = 0; g = 4'b0000; r = 8'h00; v = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      lat++;
      if (which ? busy1 : busy) bcnt++;
      g = which ? gnt1 : gnt;
      r = which ? rnd_out1 : rnd_out;
      v = which ? rnd_valid1 : rnd_valid;
      if (g != 4'b0000) break;
    end
    if (g == 4'b0000) begin
      checks++;
      errors++;
      $display("FAIL timeout: no grant within %0d cycles", lat);
    end
  endtask

  initial begin
    int lat, bcnt, gcount, dups;
    logic [3:0] g;
    logic [7:0] r, m;
    logic v;
    logic [7:0] vals [1:256];

    tbl[0] = '{4'b1111, 4'b0001, 8'h1C, 8'd9};
    tbl[1] = '{4'b1111, 4'b0010, 8'h4B, 8'd10};
    tbl[2] = '{4'b1111, 4'b0100, 8'h81, 8'd10};
    tbl[3] = '{4'b1111, 4'b1000, 8'h92, 8'd10};
    tbl[4] = '{4'b1111, 4'b0001, 8'h6E, 8'd10};

    reset = 1'b1; reset1 = 1'b1;
    req = 4'b0000; req1 = 4'b0000;
    seed_load = 1'b0; seed_load1 = 1'b0;
    seed_data = 8'h00; seed_data1 = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_gnt", gnt, 4'b0000);
    check("rst_rnd_valid", rnd_valid, 1'b0);
    check("rst_rnd_out", rnd_out, 8'h00);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Single requester: latency, busy length, first word from seed 01.
    req = 4'b0001;
    wait_gnt(1'b0, lat, bcnt, g, r, v);
    check("t1_lat", lat, 9);
    check("t1_busy_cycles", bcnt, 9);
    check("t1_gnt", g, 4'b0001);
    check("t1_rnd", r, 8'h1C);
    check("t1_valid", v, 1'b1);
    req = 4'b0000;
    @(negedge clk);
    check("t1_gnt_pulse", gnt, 4'b0000);
    check("t1_busy_drop", busy, 1'b0);
    check("t1_rnd_held", rnd_out, 8'h1C);

    // All requesters held: round-robin order, 10-cycle spacing.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req = tbl[i].req;
      wait_gnt(1'b0, lat, bcnt, g, r, v);
      check("rr_gnt", g, tbl[i].exp_gnt);
      check("rr_rnd", r, tbl[i].exp_rnd);
      check("rr_lat", lat, tbl[i].exp_lat);
      check("rr_nonzero", r != 8'h00, 1'b1);
    end
    req = 4'b0000;

    // Zero seed maps to the default seed (after a nonzero seed was loaded first).
    @(negedge clk);
    seed_load = 1'b1; seed_data = 8'hA5;
    @(negedge clk);
    seed_data = 8'h00;
    @(negedge clk);
    seed_load = 1'b0; req = 4'b0001;
    wait_gnt(1'b0, lat, bcnt, g, r, v);
    check("seed0_gnt", g, 4'b0001);
    check("seed0_rnd", r, 8'h1C);

    // Seed load while busy is ignored.
    req = 4'b0010;
    repeat (3) @(negedge clk);
    seed_load = 1'b1; seed_data = 8'hA5;
    @(negedge clk);
    seed_load = 1'b0;
    wait_gnt(1'b0, lat, bcnt, g, r, v);
    check("busy_seed_gnt", g, 4'b0010);
    check("busy_seed_rnd", r, 8'h4B);
    req = 4'b0000;

    // Seed and request in the same IDLE cycle: seed first, request one cycle later.
    @(negedge clk);
    seed_load = 1'b1; seed_data = 8'hA5; req = 4'b0100;
    @(negedge clk);
    seed_load = 1'b0;
    check("seedreq_not_busy", busy, 1'b0);
    wait_gnt(1'b0, lat, bcnt, g, r, v);
    check("seedreq_lat", lat, 9);
    check("seedreq_gnt", g, 4'b0100);
    check("seedreq_rnd", r, 8'h4E);
    req = 4'b0000;

    // Request dropped after sampling is still granted; pointer moves past it.
    @(negedge clk);
    req = 4'b0010;
    @(negedge clk);
    req = 4'b0000;
    wait_gnt(1'b0, lat, bcnt, g, r, v);
    check("drop_gnt", g, 4'b0010);
    check("drop_lat", lat, 8);
    req = 4'b0011;
    wait_gnt(1'b0, lat, bcnt, g, r, v);
    check("ptr_gnt_a", g, 4'b0001);
    req = 4'b0010;
    wait_gnt(1'b0, lat, bcnt, g, r, v);
    check("ptr_gnt_b", g, 4'b0010);
    req = 4'b0000;

    // Reset in the middle of STEP abandons the grant and restores the seed.
    @(negedge clk);
    req = 4'b0001;
    repeat (4) @(negedge clk);
    reset = 1'b1; req = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_gnt", gnt, 4'b0000);
    gcount = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (gnt != 4'b0000) gcount++;
    end
    check("midrst_no_gnt", gcount, 0);
    req = 4'b0001;
    wait_gnt(1'b0, lat, bcnt, g, r, v);
    check("midrst_rnd", r, 8'h1C);
    req = 4'b0000;

    // STEPS=1: full period sweep.
    reset1 = 1'b0;
    @(negedge clk);
    req1 = 4'b0001;
    m = 8'h01;
    for (int k = 1; k <= 256; k++) begin
      wait_gnt(1'b1, lat, bcnt, g, r, v);
      m = lfsr_model(m);
      vals[k] = r;
      check("s1_rnd", r, m);
      check("s1_lat", lat, (k == 1) ? 2 : 3);
      if (r == 8'h00) begin
        check("s1_nonzero", r != 8'h00, 1'b1);
      end
    end
    req1 = 4'b0000;
    dups = 0;
    for (int a = 1; a <= 255; a++) begin
      for (int b = a + 1; b <= 255; b++) begin
        if (vals[a] == vals[b]) dups++;
      end
    end
    check("s1_distinct", dups, 0);
    check("s1_wrap", vals[256], vals[1]);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
